pet_stats_fsm: RTL and testbench
================================

# pet_stats_fsm

Parametrised N-channel needs engine for the tamagotchi: generalises the fixed four-button pet FSM (health, energy, hunger, fun) into NUM_STATS saturating level counters. A shared tick divider drives the counters, with an accelerated test-mode rate. Levels decay on a programmable tick period and are replenished by button edges. A four-state wellbeing FSM and a rotating display selector feed the seven-segment driver downstream.

## Interface
- NUM_STATS, 4: number of need channels (1..8)
- STAT_W, 3: bits per level
- MAX_LEVEL, 5: full level; must be < 2**STAT_W
- LOW_THR, 2: level at or below which a channel is "low"
- BTN_STEP, 2: level added per button press
- TICK_DIV, 50_000_000: clk cycles per tick, normal mode
- TEST_DIV, 50_000: clk cycles per tick, test mode
- DECAY_TICKS, 10: ticks between decrements
- DEAD_TICKS, 20: consecutive CRITICAL ticks before DEAD
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- btn  in  NUM_STATS  debounced level inputs, one per channel
- btn_test  in  1  level; 1 selects TEST_DIV
- stat_level  out  NUM_STATS*STAT_W  packed levels, channel i at [i*STAT_W +: STAT_W]
- low_flags  out  NUM_STATS  bit i = stat i <= LOW_THR
- pet_state  out  2  OK=0, NEEDY=1, CRITICAL=2, DEAD=3
- tick  out  1  one-cycle pulse per tick
- disp_idx  out  3  channel currently shown
- disp_level  out  STAT_W  level of disp_idx

## Operation
- Reset values: all stat_level = MAX_LEVEL, low_flags 0, pet_state OK, tick 0, disp_idx 0, disp_level MAX_LEVEL, all counters 0, button history 0.
- Tick divider: limit = btn_test ? TEST_DIV : TICK_DIV. Each cycle, if cnt >= limit-1, then cnt <= 0 and tick pulses; else cnt increments. A mode switch with cnt already past the new limit yields a tick on the next cycle, with no long wrap.
- Decay: counts ticks. On the tick where the decay count reaches DECAY_TICKS-1, it clears and every channel decrements, saturating at 0.
- Press: a rising edge on btn[i] (current 1, registered previous 0) adds BTN_STEP to channel i, saturating at MAX_LEVEL. A held button gives exactly one increment.
- Same cycle decay and press on one channel: new = min(MAX_LEVEL, max(0, old-1) + BTN_STEP).
- FSM, evaluated from registered levels, priority top-down:
  - DEAD: absorbing. Only reset exits; button edges ignored; decay continues.
  - Any level == 0: CRITICAL. The crit counter increments per tick. When it reaches DEAD_TICKS, go to DEAD.
  - Any low_flag set: NEEDY.
  - Otherwise OK.
  - Leaving CRITICAL clears the crit counter.
- Display: on each tick, disp_idx advances and wraps NUM_STATS-1 -> 0. disp_level is registered from the selected stat.

## Timing
- Press edge sampled at edge n: stat_level updates at edge n+1; low_flags and pet_state at edge n+2.
- tick is high for exactly one cycle. Decay is applied at the edge that ends the tick cycle.
- First tick after reset release: TICK_DIV cycles later, normal mode.
- Reset is asynchronous mid-operation: all state clears immediately, including an in-progress DEAD countdown.

## Structure
- Package pet_pkg: pet_state encoding localparams (PET_OK, PET_NEEDY, PET_CRITICAL, PET_DEAD), and a saturating add/sub function.
- Sub-module pet_tick_gen: divider with test-mode select, outputs tick. One instance, reusable by the animation block.
- Channel update is a generate loop over NUM_STATS.

## Test plan
Bench params: NUM_STATS=4, STAT_W=3, MAX_LEVEL=5, LOW_THR=2, BTN_STEP=2, TICK_DIV=10, TEST_DIV=2, DECAY_TICKS=3, DEAD_TICKS=4.
- Reset release, no input -> all levels 5, pet_state 0, first tick 10 cycles later, disp_idx 1 after that tick.
- No buttons, normal mode -> levels 4 after 3 ticks. Levels 2 after 9 ticks, with low_flags 4'hF and pet_state NEEDY 2 cycles after that decay.
- btn_test=1 -> tick every 2 cycles. Toggle to 0 with cnt=5 -> next tick 5 cycles later. Toggle to 1 with cnt=7 -> tick next cycle.
- btn[1] held 20 cycles at level 4 -> level 5 exactly once, no further change. Press at level 1 coinciding with decay -> level 2.
- All levels 0 -> CRITICAL. After 4 ticks -> DEAD. btn pulses then leave levels at 0. Async reset mid-cycle -> levels 5, OK immediately.
- Channel 2 at 0, others full -> CRITICAL. Press btn[2] after 2 ticks -> level 2, NEEDY, crit counter cleared, and re-entry needs a full 4 ticks to DEAD.

Source files
------------

// File: rtl/pet_pkg.sv
// Shared definitions for the pet needs engine.
// Holds the wellbeing state encoding and a clamping add helper.
package pet_pkg;

    typedef logic [1:0] pet_state_t;

    localparam pet_state_t PET_OK       = 2'd0;
    localparam pet_state_t PET_NEEDY    = 2'd1;
    localparam pet_state_t PET_CRITICAL = 2'd2;
    localparam pet_state_t PET_DEAD     = 2'd3;

    // Add a signed delta to a level and clamp the result to [0, hi].
    function automatic int pet_sat(input int v, input int delta, input int hi);
        int r;
        r = v + delta;
        if (r < 0) begin
            r = 0;
        end else if (r > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/pet_tick_gen.sv
// Tick divider with a selectable fast rate for bring-up and demos.
// Ports: clk_i, rst_i (async, active-high), test_i selects TEST_DIV,
//        tick_o is a registered one-cycle pulse every limit cycles.
module pet_tick_gen #(
    parameter int NORM_DIV = 50_000_000,
    parameter int TEST_DIV = 50_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic test_i,
    output logic tick_o
);

    localparam int MAXD = (NORM_DIV > TEST_DIV) ? NORM_DIV : TEST_DIV;
    localparam int CW   = $clog2(MAXD + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] lim_m1;
    logic          tick_q;
    logic          tick_d;

    // The >= compare means a switch to the short period while the count
    // is already beyond it wraps on the next cycle instead of overflowing.
    always_comb begin
        lim_m1 = test_i ? CW'(TEST_DIV - 1) : CW'(NORM_DIV - 1);
        tick_d = (cnt_q >= lim_m1);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/pet_stats_fsm.sv
// N-channel needs engine: saturating levels that decay on ticks and are
// refilled by button presses, a wellbeing FSM and a rotating display pick.
// Ports: clk, reset (async, active-high), btn[NUM_STATS] press inputs,
//        btn_test fast tick select, stat_level packed levels, low_flags,
//        pet_state (OK/NEEDY/CRITICAL/DEAD), tick pulse, disp_idx and
//        disp_level for the seven-segment driver.
module pet_stats_fsm
    import pet_pkg::*;
#(
    parameter int NUM_STATS   = 4,
    parameter int STAT_W      = 3,
    parameter int MAX_LEVEL   = 5,
    parameter int LOW_THR     = 2,
    parameter int BTN_STEP    = 2,
    parameter int TICK_DIV    = 50_000_000,
    parameter int TEST_DIV    = 50_000,
    parameter int DECAY_TICKS = 10,
    parameter int DEAD_TICKS  = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_STATS-1:0]          btn,
    input  logic                          btn_test,
    output logic [NUM_STATS*STAT_W-1:0]   stat_level,
    output logic [NUM_STATS-1:0]          low_flags,
    output logic [1:0]                    pet_state,
    output logic                          tick,
    output logic [2:0]                    disp_idx,
    output logic [STAT_W-1:0]             disp_level
);

    localparam int DW  = $clog2(DECAY_TICKS + 1);
    localparam int CRW = $clog2(DEAD_TICKS + 1);

    logic                 tick_w;
    logic [NUM_STATS-1:0] btn_q;
    logic [NUM_STATS-1:0] btn_prev_q;
    logic [NUM_STATS-1:0] rise;
    logic [DW-1:0]        dcnt_q;
    logic [DW-1:0]        dcnt_d;
    logic                 decay;
    logic                 alive;
    logic [NUM_STATS-1:0] zero;
    logic [NUM_STATS-1:0] low_d;
    logic [NUM_STATS-1:0] low_q;
    pet_state_t           state_q;
    pet_state_t           state_d;
    logic [CRW-1:0]       crit_q;
    logic [CRW-1:0]       crit_d;
    logic [2:0]           idx_q;
    logic [2:0]           idx_d;
    logic [STAT_W-1:0]    disp_q;
    logic [STAT_W-1:0]    disp_d;

    pet_tick_gen #(
        .NORM_DIV (TICK_DIV),
        .TEST_DIV (TEST_DIV)
    ) u_tick (
        .clk_i  (clk),
        .rst_i  (reset),
        .test_i (btn_test),
        .tick_o (tick_w)
    );

    // Buttons pass through one sampling stage before edge detection, so a
    // press sampled at one edge lands in the level at the following edge.
    assign rise  = btn_q & ~btn_prev_q;
    assign alive = (state_q != PET_DEAD);

    // Decay fires at the edge closing every DECAY_TICKS-th tick cycle.
    always_comb begin
        decay  = tick_w && (dcnt_q == DW'(DECAY_TICKS - 1));
        dcnt_d = dcnt_q;
        if (decay) begin
            dcnt_d = '0;
        end else if (tick_w) begin
            dcnt_d = dcnt_q + DW'(1);
        end
    end

    for (genvar g = 0; g < NUM_STATS; g++) begin : g_ch
        logic [STAT_W-1:0] lvl_q;
        logic [STAT_W-1:0] lvl_d;

        // Decay is applied before the press so a coincident pair yields
        // min(MAX, max(0, old-1) + STEP).
        always_comb begin
            int v;
            v = int'(lvl_q);
            if (decay) begin
                v = pet_sat(v, -1, MAX_LEVEL);
            end
            if (rise[g] && alive) begin
                v = pet_sat(v, BTN_STEP, MAX_LEVEL);
            end
            lvl_d = STAT_W'(v);
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                lvl_q <= STAT_W'(MAX_LEVEL);
            end else begin
                lvl_q <= lvl_d;
            end
        end

        assign zero[g]  = (lvl_q == '0);
        assign low_d[g] = (lvl_q <= STAT_W'(LOW_THR));
        assign stat_level[g*STAT_W +: STAT_W] = lvl_q;
    end

    // Wellbeing next state, judged from the registered levels.
    always_comb begin
        state_d = state_q;
        crit_d  = crit_q;
        if (state_q == PET_DEAD) begin
            state_d = PET_DEAD;
        end else if (|zero) begin
            state_d = PET_CRITICAL;
            if (state_q == PET_CRITICAL && tick_w) begin
                crit_d = crit_q + CRW'(1);
                if (crit_d == CRW'(DEAD_TICKS)) begin
                    state_d = PET_DEAD;
                end
            end
        end else if (|low_d) begin
            state_d = PET_NEEDY;
        end else begin
            state_d = PET_OK;
        end
        // The countdown only survives while the pet stays critical.
        if (state_d != PET_CRITICAL) begin
            crit_d = '0;
        end
    end

    // Display rotation and selection of the shown channel.
    always_comb begin
        idx_d = idx_q;
        if (tick_w) begin
            if (idx_q == 3'(NUM_STATS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
        disp_d = stat_level[STAT_W-1:0];
        for (int i = 0; i < NUM_STATS; i++) begin
            if (idx_q == 3'(i)) begin
                disp_d = stat_level[i*STAT_W +: STAT_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_q      <= '0;
            btn_prev_q <= '0;
            dcnt_q     <= '0;
            low_q      <= '0;
            state_q    <= PET_OK;
            crit_q     <= '0;
            idx_q      <= '0;
            disp_q     <= STAT_W'(MAX_LEVEL);
        end else begin
            btn_q      <= btn;
            btn_prev_q <= btn_q;
            dcnt_q     <= dcnt_d;
            low_q      <= low_d;
            state_q    <= state_d;
            crit_q     <= crit_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
        end
    end

    always_comb begin
        pet_state  = state_q;
        low_flags  = low_q;
        tick       = tick_w;
        disp_idx   = idx_q;
        disp_level = disp_q;
    end

endmodule

// File: tb/tb_pet_stats_fsm.sv
// Self-checking bench for pet_stats_fsm with small dividers.
// Scenario tasks compare the DUT against constants and a pet model.
module tb_pet_stats_fsm;

    localparam int N     = 4;
    localparam int SW    = 3;
    localparam int MAXL  = 5;
    localparam int LOWT  = 2;
    localparam int STEP  = 2;
    localparam int TDIV  = 10;
    localparam int XDIV  = 2;
    localparam int DECAY = 3;
    localparam int DEADT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      btn;
    logic              btn_test;
    logic [N*SW-1:0]   stat_level;
    logic [N-1:0]      low_flags;
    logic [1:0]        pet_state;
    logic              tick;
    logic [2:0]        disp_idx;
    logic [SW-1:0]     disp_level;

    int n_cmp = 0;
    int n_err = 0;
    int n_ticks = 0;
    int phase = 0;

    pet_stats_fsm #(
        .NUM_STATS(N), .STAT_W(SW), .MAX_LEVEL(MAXL), .LOW_THR(LOWT),
        .BTN_STEP(STEP), .TICK_DIV(TDIV), .TEST_DIV(XDIV),
        .DECAY_TICKS(DECAY), .DEAD_TICKS(DEADT)
    ) dut (
        .clk(clk), .reset(reset), .btn(btn), .btn_test(btn_test),
        .stat_level(stat_level), .low_flags(low_flags),
        .pet_state(pet_state), .tick(tick), .disp_idx(disp_idx),
        .disp_level(disp_level)
    );

    always #5 clk = ~clk;

    // Pet model: what the pet looks like after each clock edge.
    int       m_lvl [N];
    int       m_cnt, m_tick, m_ticks_seen, m_state, m_crit, m_idx, m_disp;
    bit [N-1:0] m_low, m_seen, m_last;
    int       t_ns, t_v;
    bit       t_decay, t_any0, t_anylow;
    bit [N-1:0] t_press;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) m_lvl[i] = MAXL;
            m_cnt = 0; m_tick = 0; m_ticks_seen = 0; m_state = 0;
            m_crit = 0; m_idx = 0; m_disp = MAXL;
            m_low = '0; m_seen = '0; m_last = '0;
        end else begin
            t_any0 = 0; t_anylow = 0;
            for (int i = 0; i < N; i++) begin
                if (m_lvl[i] == 0) t_any0 = 1;
                if (m_lvl[i] <= LOWT) t_anylow = 1;
                m_low[i] = (m_lvl[i] <= LOWT);
            end
            t_press = m_seen & ~m_last;
            t_decay = 0;
            if (m_tick != 0) begin
                m_ticks_seen++;
                if (m_ticks_seen == DECAY) begin
                    m_ticks_seen = 0;
                    t_decay = 1;
                end
            end
            t_ns = m_state;
            if (m_state == 3) begin
                t_ns = 3;
            end else if (t_any0) begin
                if (m_state == 2) begin
                    if (m_tick != 0) m_crit++;
                end else begin
                    m_crit = 0;
                end
                t_ns = (m_crit == DEADT) ? 3 : 2;
            end else begin
                m_crit = 0;
                t_ns = t_anylow ? 1 : 0;
            end
            m_disp = m_lvl[m_idx];
            if (m_tick != 0) m_idx = (m_idx + 1) % N;
            for (int i = 0; i < N; i++) begin
                t_v = m_lvl[i];
                if (t_decay && t_v > 0) t_v = t_v - 1;
                if (t_press[i] && m_state != 3) begin
                    t_v = t_v + STEP;
                    if (t_v > MAXL) t_v = MAXL;
                end
                m_lvl[i] = t_v;
            end
            m_state = t_ns;
            m_last = m_seen;
            m_seen = btn;
            if (m_cnt >= (btn_test ? XDIV : TDIV) - 1) begin
                m_tick = 1; m_cnt = 0;
            end else begin
                m_tick = 0; m_cnt++;
            end
        end
    end

    function automatic logic [N*SW-1:0] m_pack();
        logic [N*SW-1:0] r;
        for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'(m_lvl[i]);
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
        if (tick === 1'b1) n_ticks++;
    endtask

    task automatic do_reset();
        reset = 1'b1; btn = '0; btn_test = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_ticks = 0;
    endtask

    task automatic test_reset();
        int cyc;
        reset = 1'b1; btn = '0; btn_test = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (stat_level !== 12'hB6D) begin
            n_err++; $display("FAIL reset_levels: got %h, expected b6d", stat_level);
        end
        n_cmp++;
        if (low_flags !== 4'h0 || pet_state !== 2'd0 || tick !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: got low=%h st=%0d tick=%b, expected 0 0 0",
                     low_flags, pet_state, tick);
        end
        n_cmp++;
        if (disp_idx !== 3'd0 || disp_level !== 3'd5) begin
            n_err++;
            $display("FAIL reset_disp: got idx=%0d lvl=%0d, expected 0 5", disp_idx, disp_level);
        end
        @(negedge clk);
        reset = 1'b0;
        n_ticks = 0;
        cyc = 0;
        do begin step(); cyc++; end while (tick !== 1'b1 && cyc < 50);
        n_cmp++;
        if (cyc != TDIV) begin
            n_err++; $display("FAIL first_tick: got %0d cycles, expected %0d", cyc, TDIV);
        end
        step();
        n_cmp++;
        if (disp_idx !== 3'd1) begin
            n_err++; $display("FAIL disp_advance: got %0d, expected 1", disp_idx);
        end
    endtask

    task automatic test_decay();
        int g;
        g = 0;
        while (n_ticks < 3 && g < 100) begin step(); g++; end
        step();
        n_cmp++;
        if (stat_level !== 12'h924 || stat_level !== m_pack()) begin
            n_err++; $display("FAIL decay_3_ticks: got %h, expected 924", stat_level);
        end
        g = 0;
        while (n_ticks < 9 && g < 200) begin step(); g++; end
        step();
        n_cmp++;
        if (stat_level !== 12'h492) begin
            n_err++; $display("FAIL decay_9_ticks: got %h, expected 492", stat_level);
        end
        n_cmp++;
        if (low_flags !== 4'h0 || pet_state !== 2'd0) begin
            n_err++;
            $display("FAIL flags_lag: got low=%h st=%0d, expected 0 0", low_flags, pet_state);
        end
        step();
        n_cmp++;
        if (low_flags !== 4'hF || pet_state !== 2'd1) begin
            n_err++;
            $display("FAIL needy: got low=%h st=%0d, expected f 1", low_flags, pet_state);
        end
    endtask

    task automatic test_tick_mode();
        int cyc;
        do_reset();
        btn_test = 1'b1;
        cyc = 0;
        do begin step(); cyc++; end while (tick !== 1'b1 && cyc < 40);
        cyc = 0;
        do begin step(); cyc++; end while (tick !== 1'b1 && cyc < 40);
        n_cmp++;
        if (cyc != XDIV) begin
            n_err++; $display("FAIL test_period: got %0d, expected %0d", cyc, XDIV);
        end
        btn_test = 1'b0;
        cyc = 0;
        do begin step(); cyc++; end while (tick !== 1'b1 && cyc < 40);
        repeat (5) step();
        cyc = 0;
        do begin step(); cyc++; end while (tick !== 1'b1 && cyc < 40);
        n_cmp++;
        if (cyc != 5) begin
            n_err++; $display("FAIL from_cnt5: got %0d, expected 5", cyc);
        end
        repeat (7) step();
        btn_test = 1'b1;
        step();
        n_cmp++;
        if (tick !== 1'b1) begin
            n_err++; $display("FAIL switch_fast: got %b, expected 1", tick);
        end
        for (int c = 0; c < 200; c++) begin
            if ($urandom_range(0, 7) == 0) btn_test = ~btn_test;
            step();
            n_cmp++;
            if (tick !== 1'(m_tick)) begin
                n_err++; $display("FAIL rand_tick c=%0d: got %b, expected %0d", c, tick, m_tick);
            end
        end
    endtask

    task automatic test_hold_press();
        int g, incs;
        logic [SW-1:0] prev;
        do_reset();
        g = 0;
        while (n_ticks < 3 && g < 100) begin step(); g++; end
        step();
        btn = 4'b0010;
        incs = 0;
        prev = stat_level[5:3];
        for (int c = 0; c < 20; c++) begin
            step();
            if (stat_level[5:3] > prev) incs++;
            prev = stat_level[5:3];
        end
        n_cmp++;
        if (stat_level[5:3] !== 3'd5 || incs != 1) begin
            n_err++;
            $display("FAIL hold_once: got lvl=%0d incs=%0d, expected 5 1", stat_level[5:3], incs);
        end
        n_cmp++;
        if (stat_level !== m_pack()) begin
            n_err++; $display("FAIL hold_model: got %h, expected %h", stat_level, m_pack());
        end
        btn = '0;
    endtask

    task automatic test_press_decay();
        int g;
        do_reset();
        btn_test = 1'b1;
        g = 0;
        while (!(m_lvl[0] == 1 && tick === 1'b0 && m_ticks_seen == DECAY - 1)
               && g < 200) begin
            step(); g++;
        end
        n_cmp++;
        if (g >= 200) begin
            n_err++; $display("FAIL press_decay_setup: got timeout %0d, expected <200", g);
        end
        btn = 4'b0001;
        step();
        n_cmp++;
        if (stat_level !== 12'h249) begin
            n_err++; $display("FAIL pre_decay: got %h, expected 249", stat_level);
        end
        step();
        n_cmp++;
        if (stat_level !== 12'h002) begin
            n_err++; $display("FAIL press_with_decay: got %h, expected 002", stat_level);
        end
        btn = '0;
    endtask

    task automatic test_dead();
        int g, ct;
        do_reset();
        btn_test = 1'b1;
        g = 0;
        while (pet_state !== 2'd2 && g < 200) begin step(); g++; end
        n_cmp++;
        if (stat_level !== 12'h000 || pet_state !== 2'd2) begin
            n_err++;
            $display("FAIL critical: got %h st=%0d, expected 000 2", stat_level, pet_state);
        end
        ct = 0; g = 0;
        while (pet_state !== 2'd3 && g < 100) begin
            if (tick === 1'b1 && pet_state === 2'd2) ct++;
            step(); g++;
        end
        n_cmp++;
        if (pet_state !== 2'd3 || ct != DEADT) begin
            n_err++;
            $display("FAIL dead_after: got st=%0d ticks=%0d, expected 3 %0d", pet_state, ct, DEADT);
        end
        for (int c = 0; c < 12; c++) begin
            btn = (c % 2 == 0) ? 4'hF : 4'h0;
            step();
        end
        btn = '0;
        n_cmp++;
        if (stat_level !== 12'h000 || pet_state !== 2'd3) begin
            n_err++;
            $display("FAIL dead_ignores_btn: got %h st=%0d, expected 000 3", stat_level, pet_state);
        end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (stat_level !== 12'hB6D || pet_state !== 2'd0 || low_flags !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset: got %h st=%0d low=%h, expected b6d 0 0",
                     stat_level, pet_state, low_flags);
        end
        @(negedge clk);
        reset = 1'b0;
        n_ticks = 0;
    endtask

    task automatic drive_step(input bit b2);
        bit ph;
        ph = 1'((phase >> 1) & 1);
        btn = {ph, b2, ph, ph};
        phase++;
        step();
    endtask

    task automatic test_revive();
        int g, ct;
        do_reset();
        btn_test = 1'b1;
        g = 0;
        while (pet_state !== 2'd2 && g < 300) begin drive_step(1'b0); g++; end
        n_cmp++;
        if (stat_level[8:6] !== 3'd0 || pet_state !== 2'd2 || stat_level[2:0] == 3'd0) begin
            n_err++;
            $display("FAIL ch2_critical: got %h st=%0d, expected ch2=0 st=2", stat_level, pet_state);
        end
        ct = 0; g = 0;
        while (ct < 2 && g < 100) begin
            if (tick === 1'b1 && pet_state === 2'd2) ct++;
            drive_step(1'b0); g++;
        end
        drive_step(1'b1);
        drive_step(1'b1);
        n_cmp++;
        if (stat_level[8:6] !== 3'd2) begin
            n_err++; $display("FAIL revive_level: got %0d, expected 2", stat_level[8:6]);
        end
        drive_step(1'b0);
        n_cmp++;
        if (pet_state !== 2'd1) begin
            n_err++; $display("FAIL revive_needy: got %0d, expected 1", pet_state);
        end
        g = 0;
        while (pet_state !== 2'd2 && g < 300) begin drive_step(1'b0); g++; end
        ct = 0; g = 0;
        while (pet_state !== 2'd3 && g < 100) begin
            if (tick === 1'b1 && pet_state === 2'd2) ct++;
            drive_step(1'b0); g++;
        end
        n_cmp++;
        if (pet_state !== 2'd3 || ct != DEADT) begin
            n_err++;
            $display("FAIL reentry_count: got st=%0d ticks=%0d, expected 3 %0d", pet_state, ct, DEADT);
        end
        btn = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 19) == 0) btn_test = ~btn_test;
            if ($urandom_range(0, 2) == 0) btn = 4'($urandom);
            step();
            n_cmp++;
            if (stat_level !== m_pack()) begin
                n_err++; $display("FAIL rnd_levels c=%0d: got %h, expected %h", c, stat_level, m_pack());
            end
            n_cmp++;
            if (low_flags !== m_low || pet_state !== 2'(m_state)) begin
                n_err++;
                $display("FAIL rnd_state c=%0d: got low=%h st=%0d, expected %h %0d",
                         c, low_flags, pet_state, m_low, m_state);
            end
            n_cmp++;
            if (tick !== 1'(m_tick) || disp_idx !== 3'(m_idx) || disp_level !== SW'(m_disp)) begin
                n_err++;
                $display("FAIL rnd_disp c=%0d: got t=%b i=%0d l=%0d, expected %0d %0d %0d",
                         c, tick, disp_idx, disp_level, m_tick, m_idx, m_disp);
            end
        end
        btn = '0;
    endtask

    initial begin
        test_reset();
        test_decay();
        test_tick_mode();
        test_hold_press();
        test_press_decay();
        test_dead();
        test_revive();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
